mix_column_serial: RTL and testbench

MIX_COLUMN_SERIAL -- requirements
Module: mix_column_serial

---
 rtl/mix_column_serial.sv | 127 ++++++++++++
 tb/tb_mix_column_serial.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mix_column_serial.sv
// AES MixColumns / InvMixColumns engine, one 32-bit column per clock.
// Accepts a full state, runs four column cycles, then holds the result until taken.
module mix_column_serial (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_dec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [1:0]   cnt_q;
    logic [127:0] in_q;
    logic [127:0] res_q;
    logic         dec_q;
    logic [31:0]  col;
    logic [31:0]  mixed;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // k is the circulant offset: enc {2,3,1,1}, dec {E,B,D,9}
    function automatic logic [7:0] gf_mul(
        input logic [7:0] b,
        input logic [1:0] k,
        input logic       dec
    );
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case ({dec, k})
            3'b000:  gf_mul = x2;
            3'b001:  gf_mul = x2 ^ b;
            3'b010:  gf_mul = b;
            3'b011:  gf_mul = b;
            3'b100:  gf_mul = x8 ^ x4 ^ x2;
            3'b101:  gf_mul = x8 ^ x2 ^ b;
            3'b110:  gf_mul = x8 ^ x4 ^ b;
            default: gf_mul = x8 ^ b;
        endcase
    endfunction

    function automatic logic [31:0] mix_col(
        input logic [31:0] c,
        input logic        dec
    );
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        mix_col[31:24] = gf_mul(a0, 2'd0, dec) ^ gf_mul(a1, 2'd1, dec)
                       ^ gf_mul(a2, 2'd2, dec) ^ gf_mul(a3, 2'd3, dec);
        mix_col[23:16] = gf_mul(a1, 2'd0, dec) ^ gf_mul(a2, 2'd1, dec)
                       ^ gf_mul(a3, 2'd2, dec) ^ gf_mul(a0, 2'd3, dec);
        mix_col[15:8]  = gf_mul(a2, 2'd0, dec) ^ gf_mul(a3, 2'd1, dec)
                       ^ gf_mul(a0, 2'd2, dec) ^ gf_mul(a1, 2'd3, dec);
        mix_col[7:0]   = gf_mul(a3, 2'd0, dec) ^ gf_mul(a0, 2'd1, dec)
                       ^ gf_mul(a1, 2'd2, dec) ^ gf_mul(a2, 2'd3, dec);
    endfunction

    // Column j lives at bit offset 32*(3-j), i.e. {~j, 5'b0}
    assign col   = in_q[{~cnt_q, 5'd0} +: 32];
    assign mixed = mix_col(col, dec_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)      state_d = RUN;
            RUN:     if (cnt_q == 2'd3) state_d = DONE;
            DONE:    if (out_ready)     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 2'd0;
            in_q  <= '0;
            dec_q <= 1'b0;
            res_q <= '0;
        end else begin
            if (state_q == IDLE && in_valid) begin
                in_q  <= in_state;
                dec_q <= in_dec;
                cnt_q <= 2'd0;
            end
            if (state_q == RUN) begin
                res_q[{~cnt_q, 5'd0} +: 32] <= mixed;
                cnt_q <= cnt_q + 2'd1;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_state = res_q;

endmodule

// File: tb/tb_mix_column_serial.sv
// Directed + randomized bench for mix_column_serial against a
// matrix-level GF(2^8) reference model.
module tb_mix_column_serial;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_dec;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [127:0] PLAIN = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] MIXED = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

    mix_column_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_dec    (in_dec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Shift-and-add GF(2^8) product
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic d);
        logic [7:0]   m [4];
        logic [127:0] r;
        logic [7:0]   acc;
        if (d) begin
            m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        end else begin
            m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
        end
        r = '0;
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(m[(k - i + 4) % 4], s[127 - 32*j - 8*k -: 8]);
                r[127 - 32*j - 8*i -: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // noise: 0 quiet, 1 random out_ready during RUN, 2 also scramble in_* during RUN
    task automatic run_txn(
        input  logic [127:0] s,
        input  logic         d,
        input  int           hold,
        input  int           noise,
        output logic [127:0] got
    );
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        chk("in_ready_before_accept", in_ready, 1'b1);
        in_valid = 1'b1;
        in_state = s;
        in_dec   = d;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("no_early_valid", out_valid, 1'b0);
            chk("busy_in_run", {in_ready, busy}, 2'b01);
            if (noise >= 1) out_ready = 1'($urandom);
            if (noise >= 2) begin
                in_valid = 1'($urandom);
                in_dec   = ~in_dec;
                in_state = {$urandom, $urandom, $urandom, $urandom};
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("valid_after_4", out_valid, 1'b1);
        got = out_state;
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_valid", {out_valid, in_ready, busy}, 3'b101);
            chk("hold_stable", out_state, got);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("release_idle", {out_valid, in_ready, busy}, 3'b010);
        chk("idle_keeps_result", out_state, got);
    endtask

    logic [127:0] r;
    logic [127:0] x;
    logic [127:0] y;
    logic         d;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_state  = '0;
        in_dec    = 1'b0;
        out_ready = 1'b0;
        #2;
        chk("reset_outputs", {in_ready, out_valid, busy}, 3'b100);
        chk("reset_state", out_state, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_txn(PLAIN, 1'b0, 0, 0, r);
        chk("enc_vector", r, MIXED);
        chk("enc_model", r, model(PLAIN, 1'b0));

        run_txn(MIXED, 1'b1, 0, 0, r);
        chk("dec_vector", r, PLAIN);

        run_txn(PLAIN, 1'b0, 10, 0, r);
        chk("backpressure_result", r, MIXED);

        run_txn(PLAIN, 1'b0, 2, 2, r);
        chk("glitch_result", r, MIXED);

        // Abort while column 2 is in flight
        in_valid = 1'b1;
        in_state = PLAIN;
        in_dec   = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("mid_run_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {in_ready, out_valid, busy}, 3'b100);
        chk("abort_state", out_state, 128'h0);
        step();
        step();
        chk("abort_no_valid", out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("post_reset_state", out_state, 128'h0);
        run_txn(MIXED, 1'b1, 0, 0, r);
        chk("post_reset_dec", r, PLAIN);

        for (int t = 0; t < 20; t++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            d = 1'($urandom);
            run_txn(x, d, $urandom_range(0, 3), 1, r);
            chk("rand_model", r, model(x, d));
            run_txn(x, 1'b0, $urandom_range(0, 3), 1, y);
            chk("rand_enc_model", y, model(x, 1'b0));
            run_txn(y, 1'b1, $urandom_range(0, 3), 1, r);
            chk("rand_roundtrip", r, x);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
